rw_bus_responder: RTL and testbench
===================================

// Module: rw_bus_responder
// PURPOSE
//  Memory-side responder for the read/write arbiter bus: answers read and writeback requests issued by the arbiter.
//  Accepts one request at a time: reqack pulse, then LATENCY-cycle service delay, then a read response or writeack.
//  Backs requests with an internal word-addressed array. Used as the sysbus end for cache/arbiter bring-up.
// PARAMETERS
//  WIDTH       64  data/address width of req, reqdata, resp
//  TAG_WIDTH   13  tag width; reqtag[TAG_WIDTH-1] = 1 write, 0 read
//  DEPTH_LOG2  10  log2 of array words (1024 x WIDTH)
//  LATENCY     4   cycles from reqack to completion; legal range 2..255
// PORTS
//  clk       in   1          clock, all state on posedge
//  reset     in   1          asynchronous, active-high reset
//  reqcyc    in   1          request valid, held by arbiter until it sees reqack
//  req       in   WIDTH      byte address; word index = req[DEPTH_LOG2+2:3]
//  reqtag    in   TAG_WIDTH  request tag; MSB selects write/read
//  reqdata   in   WIDTH      write data, valid with reqcyc on writes
//  reqack    out  1          one-cycle pulse: request captured
//  respcyc   out  1          read response valid, held until respack
//  resp      out  WIDTH      read data; 0 whenever respcyc=0
//  resptag   out  TAG_WIDTH  captured reqtag, valid with respcyc
//  respack   in   1          arbiter consumed response
//  writeack  out  1          one-cycle pulse: write committed
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, latency counter 0, capture regs 0. Array contents not reset.
//  Reset mid-transaction: abort immediately; an uncommitted write is dropped; no ack/resp is issued afterwards.
//  States: IDLE, WAIT, RESP, DRAIN.
//  IDLE: if reqcyc=1, capture req index, reqtag, reqdata; reqack<=1 for exactly one cycle; cnt<=LATENCY-1; ->WAIT.
//  WAIT: reqack<=0; reqcyc ignored. If cnt!=0, cnt<=cnt-1.
//   At cnt=0 with write tag: array[idx]<=data; writeack<=1 for one cycle; ->DRAIN.
//   At cnt=0 with read tag: respcyc<=1, resp<=array[idx], resptag<=tag; ->RESP.
//  Latency: reqack rises 1 cycle after reqcyc sampled.
//   writeack / respcyc rise LATENCY cycles after the reqack edge.
//  RESP: hold respcyc/resp/resptag stable until respack=1 sampled; then respcyc<=0, resp<=0; ->DRAIN.
//   respack while respcyc=0 is ignored in every state.
//  DRAIN: writeack<=0; ->IDLE when reqcyc=0. A stale reqcyc is never taken as a new request.
//  Throughput: one transaction in flight; at most one new request is accepted per IDLE visit.
//  Address: bits above the index field are ignored, so addresses wrap modulo 2^DEPTH_LOG2 words; bits [2:0] are ignored.
//  Read-after-write to the same index returns the new data; the write commits before any later request is accepted.
//  reqack, writeack and respcyc are registered outputs; no combinational input-to-output paths.
//  reqack and writeack never assert in the same cycle. respcyc and writeack are never both 1.
// TESTING
//  1 Reset: assert reset mid-cycle, async -> all outputs 0 before next edge; state IDLE after release.
//  2 Write then read: write tag 0x1000 addr 0x40 data 0xDEADBEEF_CAFEF00D.
//    -> reqack at T+1, writeack at T+1+LATENCY.
//    Then read tag 0x0005 addr 0x40 -> respcyc, resp=0xDEADBEEF_CAFEF00D, resptag=0x0005.
//  3 Respack stall: hold respack=0 for 10 cycles -> respcyc and resp stay stable throughout.
//    respack=1 -> respcyc=0 and resp=0 next cycle.
//  4 Wrap/alias: write addr 0x2040 (DEPTH_LOG2=10) data 0x1, read addr 0x0040 -> resp=0x1.
//    Low bits: read addr 0x0047 -> resp=0x1.
//  5 Stale reqcyc: keep reqcyc=1 after the response completes -> no second reqack until reqcyc drops.
//    reqcyc dropped and re-asserted -> a new transaction starts.
//  6 Reset during WAIT of write to addr 0x80 -> no writeack.
//    A later read of 0x80 returns the pre-write value (bench preloads 0x80 before the aborted write).

Source files
------------

// File: rtl/rw_bus_responder.sv
// ============================================================================
//  Module   : rw_bus_responder
//  Brief    : Memory-side responder for the read/write arbiter bus, backed by
//             an internal word-addressed array with fixed service latency.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rw_bus_responder #(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned TAG_WIDTH  = 13,
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 reqcyc_i,
   input  logic [WIDTH-1:0]     req_i,
   input  logic [TAG_WIDTH-1:0] reqtag_i,
   input  logic [WIDTH-1:0]     reqdata_i,
   output logic                 reqack_o,
   output logic                 respcyc_o,
   output logic [WIDTH-1:0]     resp_o,
   output logic [TAG_WIDTH-1:0] resptag_o,
   input  logic                 respack_i,
   output logic                 writeack_o
);

   localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
   localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_RESP  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic                   reqack_q, reqack_d;
   logic                   writeack_q, writeack_d;
   logic                   respcyc_q, respcyc_d;
   logic [WIDTH-1:0]       resp_q, resp_d;
   logic [TAG_WIDTH-1:0]   resptag_q, resptag_d;
   logic                   mem_we;

   logic [WIDTH-1:0]       mem_q [DEPTH];

   // Byte-offset and above-index address bits are don't-care by design.
   logic w_unused_req;
   assign w_unused_req = ^{req_i[2:0], req_i[WIDTH-1:DEPTH_LOG2+3]};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         tag_q      <= '0;
         data_q     <= '0;
         reqack_q   <= 1'b0;
         writeack_q <= 1'b0;
         respcyc_q  <= 1'b0;
         resp_q     <= '0;
         resptag_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         tag_q      <= tag_d;
         data_q     <= data_d;
         reqack_q   <= reqack_d;
         writeack_q <= writeack_d;
         respcyc_q  <= respcyc_d;
         resp_q     <= resp_d;
         resptag_q  <= resptag_d;
      end
   end

   // Array is not reset; a write only lands on the commit edge in WAIT.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[idx_q] <= data_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      tag_d      = tag_q;
      data_d     = data_q;
      reqack_d   = 1'b0;
      writeack_d = 1'b0;
      respcyc_d  = respcyc_q;
      resp_d     = resp_q;
      resptag_d  = resptag_q;
      mem_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (reqcyc_i) begin
               idx_d    = req_i[DEPTH_LOG2+2:3];
               tag_d    = reqtag_i;
               data_d   = reqdata_i;
               reqack_d = 1'b1;
               cnt_d    = LAT_M1;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (tag_q[TAG_WIDTH-1]) begin
               mem_we     = 1'b1;
               writeack_d = 1'b1;
               state_d    = S_DRAIN;
            end else begin
               respcyc_d = 1'b1;
               resp_d    = mem_q[idx_q];
               resptag_d = tag_q;
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            if (respack_i) begin
               respcyc_d = 1'b0;
               resp_d    = '0;
               state_d   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Wait for the arbiter to drop reqcyc so a held request is not re-taken.
            if (!reqcyc_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign reqack_o   = reqack_q;
   assign writeack_o = writeack_q;
   assign respcyc_o  = respcyc_q;
   assign resp_o     = resp_q;
   assign resptag_o  = resptag_q;

endmodule

`default_nettype wire

// File: tb/tb_rw_bus_responder.sv
// ============================================================================
//  Module   : tb_rw_bus_responder
//  Brief    : Directed self-checking bench for rw_bus_responder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rw_bus_responder;

   localparam int L = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqcyc;
   logic [63:0] req;
   logic [12:0] reqtag;
   logic [63:0] reqdata;
   logic        reqack;
   logic        respcyc;
   logic [63:0] resp;
   logic [12:0] resptag;
   logic        respack;
   logic        writeack;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rw_bus_responder #(
      .WIDTH(64), .TAG_WIDTH(13), .DEPTH_LOG2(10), .LATENCY(L)
   ) dut (
      .clk_i(clk), .reset_i(reset), .reqcyc_i(reqcyc), .req_i(req),
      .reqtag_i(reqtag), .reqdata_i(reqdata), .reqack_o(reqack),
      .respcyc_o(respcyc), .resp_o(resp), .resptag_o(resptag),
      .respack_i(respack), .writeack_o(writeack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", name, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_reqack"},   {63'd0, reqack},   64'd0);
      check({name, "_writeack"}, {63'd0, writeack}, 64'd0);
      check({name, "_respcyc"},  {63'd0, respcyc},  64'd0);
      check({name, "_resp"},     resp,              64'd0);
      check({name, "_resptag"},  {51'd0, resptag},  64'd0);
   endtask

   task automatic write_txn(input logic [63:0] addr, input logic [63:0] data, input logic [12:0] tag);
      reqcyc = 1'b1; req = addr; reqtag = tag; reqdata = data;
      tick();
      check("wr_reqack", {63'd0, reqack}, 64'd1);
      reqcyc = 1'b0;
      for (int i = 0; i < L - 1; i++) begin
         tick();
         check("wr_wait_writeack", {63'd0, writeack}, 64'd0);
      end
      tick();
      check("wr_writeack", {63'd0, writeack}, 64'd1);
      check("wr_no_respcyc", {63'd0, respcyc}, 64'd0);
      tick();
      check("wr_writeack_pulse", {63'd0, writeack}, 64'd0);
   endtask

   task automatic read_start(input logic [63:0] addr, input logic [12:0] tag,
                             input logic [63:0] exp, input bit hold);
      reqcyc = 1'b1; req = addr; reqtag = tag; reqdata = 64'h0;
      tick();
      check("rd_reqack", {63'd0, reqack}, 64'd1);
      if (!hold) reqcyc = 1'b0;
      for (int i = 0; i < L - 1; i++) begin
         tick();
         check("rd_wait_respcyc", {63'd0, respcyc}, 64'd0);
      end
      tick();
      check("rd_respcyc", {63'd0, respcyc}, 64'd1);
      check("rd_resp", resp, exp);
      check("rd_resptag", {51'd0, resptag}, {51'd0, tag});
      check("rd_no_writeack", {63'd0, writeack}, 64'd0);
   endtask

   task automatic read_finish();
      respack = 1'b1;
      tick();
      respack = 1'b0;
      check("rd_done_respcyc", {63'd0, respcyc}, 64'd0);
      check("rd_done_resp", resp, 64'd0);
      tick();
   endtask

   initial begin
      reset = 1'b1; reqcyc = 1'b0; req = '0; reqtag = '0; reqdata = '0; respack = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
      check("idle_no_reqack", {63'd0, reqack}, 64'd0);

      // Write then read back with a distinct read tag.
      write_txn(64'h40, 64'hDEADBEEF_CAFEF00D, 13'h1000);
      read_start(64'h40, 13'h0005, 64'hDEADBEEF_CAFEF00D, 1'b0);

      // Response must hold while respack stays low.
      for (int i = 0; i < 10; i++) begin
         tick();
         check("stall_respcyc", {63'd0, respcyc}, 64'd1);
         check("stall_resp", resp, 64'hDEADBEEF_CAFEF00D);
      end
      read_finish();

      // Upper address bits alias onto the same word; low byte bits ignored.
      write_txn(64'h2040, 64'h1, 13'h1001);
      read_start(64'h40, 13'h0006, 64'h1, 1'b0);
      read_finish();
      read_start(64'h47, 13'h0007, 64'h1, 1'b0);
      read_finish();

      // Asynchronous reset while a response is pending.
      read_start(64'h40, 13'h0009, 64'h1, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      check("post_reset_respcyc", {63'd0, respcyc}, 64'd0);

      // Held reqcyc after completion must not start another transaction.
      read_start(64'h40, 13'h000A, 64'h1, 1'b1);
      read_finish();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stale_no_reqack", {63'd0, reqack}, 64'd0);
      end
      reqcyc = 1'b0;
      tick();
      read_start(64'h40, 13'h000B, 64'h1, 1'b0);
      read_finish();

      // Reset during the WAIT of a write drops it.
      write_txn(64'h80, 64'h1111_2222_3333_4444, 13'h1002);
      reqcyc = 1'b1; req = 64'h80; reqtag = 13'h1003; reqdata = 64'hBAD;
      tick();
      check("abort_reqack", {63'd0, reqack}, 64'd1);
      reqcyc = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("abort_writeack_in_reset", {63'd0, writeack}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_writeack", {63'd0, writeack}, 64'd0);
      end
      read_start(64'h80, 13'h0002, 64'h1111_2222_3333_4444, 1'b0);
      read_finish();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
